// File: rtl/fact_accel.sv
// rtl/fact_accel.sv - memory-mapped iterative factorial accelerator
// Optional completion interrupt and STATUS write-to-clear: FACT_ACCEL_IRQ_EN
module fact_accel #(
    parameter int MAX_N = 12,
    parameter int N_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd
`ifdef FACT_ACCEL_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);
    localparam logic [N_W-1:0] ONE     = N_W'(1);

    state_t         state_q, state_d;
    logic [N_W-1:0] n_q, n_d;
    logic [N_W-1:0] cnt_q, cnt_d;
    logic [31:0]    prod_q, prod_d;
    logic [31:0]    result_q, result_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [31:0]    prod_mul;
    logic           go_acc;
    logic           busy;

    assign busy     = (state_q == BUSY);
    assign go_acc   = we && (a == 2'd1) && wd[0] && (state_q == IDLE);
    assign prod_mul = prod_q * {{(32-N_W){1'b0}}, cnt_q};

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        result_d = result_q;
        done_d   = done_q;
        err_d    = err_q;

        if (we && (a == 2'd0)) begin
            n_d = wd[N_W-1:0];
        end

`ifdef FACT_ACCEL_IRQ_EN
        // Clear is applied first so a coinciding completion below overrides it.
        if (we && (a == 2'd2)) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (go_acc) begin
                    if (n_q <= MAX_N_V) begin
                        cnt_d   = n_q;
                        prod_d  = 32'd1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = BUSY;
                    end else begin
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                        result_d = 32'd0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q > ONE) begin
                    prod_d = prod_mul;
                    cnt_d  = cnt_q - ONE;
                end else begin
                    result_d = prod_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            prod_q   <= 32'd1;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef FACT_ACCEL_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = done_q;
        if (we && (a == 2'd2)) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        rd = 32'd0;
        case (a)
            2'd0:    rd = {{(32-N_W){1'b0}}, n_q};
            2'd1:    rd = {31'd0, busy};
            2'd2:    rd = {30'd0, err_q, done_q};
            default: rd = result_q;
        endcase
    end

endmodule

// File: tb/tb_fact_accel.sv
// tb/tb_fact_accel.sv - directed scoreboard bench for fact_accel
module tb_fact_accel;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  a = 2'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
`ifdef FACT_ACCEL_IRQ_EN
    logic        irq;
`endif

    int passed = 0;
    int total  = 0;
    logic [31:0] sb[$];

    fact_accel dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .a    (a),
        .wd   (wd),
        .rd   (rd)
`ifdef FACT_ACCEL_IRQ_EN
        ,
        .irq  (irq)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fact(input int n);
        longint p = 1;
        for (int i = 2; i <= n; i++) p = p * i;
        return p[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rdreg(input logic [1:0] addr, output logic [31:0] v);
        a = addr;
        #1;
        v = rd;
    endtask

    task automatic start(input int n);
        wr(2'd0, n);
        wr(2'd1, 32'd1);
        if (n <= 12) sb.push_back(fact(n));
    endtask

    task automatic wait_done(output int lat);
        logic [31:0] v;
        lat = 0;
        rdreg(2'd2, v);
        while (!v[0] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            rdreg(2'd2, v);
        end
    endtask

    task automatic finish_run(input string tag, input int exp_lat);
        int lat;
        logic [31:0] v;
        logic [31:0] exp;
        wait_done(lat);
        if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
        rdreg(2'd2, v);
        check({tag, "_status"}, v, 32'h1);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        rdreg(2'd3, v);
        check({tag, "_result"}, v, exp);
    endtask

    initial begin
        logic [31:0] v;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            rdreg(i[1:0], v);
            check("reset_reg", v, 32'd0);
        end

        start(5);
        rdreg(2'd1, v);
        check("n5_busy", v, 32'd1);
        finish_run("n5", 5);

        start(0);
        finish_run("n0", 1);
        start(1);
        finish_run("n1", 1);

        start(12);
        finish_run("n12", 12);
        rdreg(2'd3, v);
        check("n12_const", v, 32'h1C8C_FC00);

        start(13);
        rdreg(2'd2, v);
        check("n13_status", v, 32'h3);
        rdreg(2'd3, v);
        check("n13_result", v, 32'd0);
        for (int i = 0; i < 3; i++) begin
            rdreg(2'd1, v);
            check("n13_busy", v, 32'd0);
            @(posedge clk);
            #1;
        end

        start(3);
        finish_run("n3_after_err", 3);

        start(6);
        wr(2'd0, 32'd2);
        wr(2'd1, 32'd1);
        rdreg(2'd1, v);
        check("n6_still_busy", v, 32'd1);
        finish_run("n6_midrun", -1);
        rdreg(2'd0, v);
        check("n6_n_reads", v, 32'd2);
        @(posedge clk);
        #1;
        rdreg(2'd1, v);
        check("n6_no_restart", v, 32'd0);

        start(7);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        for (int i = 0; i < 4; i++) begin
            rdreg(i[1:0], v);
            check("midrun_reset_reg", v, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start(4);
        finish_run("n4_after_reset", 4);

`ifdef FACT_ACCEL_IRQ_EN
        start(3);
        finish_run("irq_n3", 3);
        check("irq_low_at_done", irq, 32'd0);
        @(posedge clk);
        #1;
        check("irq_high_next", irq, 32'd1);
        wr(2'd2, 32'd0);
        rdreg(2'd2, v);
        check("irq_clear_status", v, 32'd0);
        check("irq_clear_irq", irq, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fact_accel.md
# fact_accel

Memory-mapped factorial accelerator that responds on the processor's data bus behind the address decoder. It is selected by the decoder's per-peripheral write enable and read-select path. Software writes an operand and a start command, polls status, then reads the 32-bit result. Internally a small FSM computes n! iteratively, one multiply per clock.

## Interface
- `MAX_N`, default 12: largest operand accepted; 13! overflows 32 bits.
- `N_W`, default 4: operand register width; must satisfy `MAX_N < 2**N_W`.
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `we`, input, 1: write strobe for this peripheral (decoder output); sampled on `clk`.
- `a`, input, 2: word offset, address bits [3:2]. 0 = N, 1 = GO/BUSY, 2 = STATUS, 3 = RESULT.
- `wd`, input, 32: write data.
- `rd`, output, 32: read data, combinational from `a`.
- `irq`, output, 1: completion interrupt; present only with `FACT_ACCEL_IRQ_EN`.

## Operation
Registers:
- N (offset 0): R/W, `wd[N_W-1:0]`. Writable at any time. Writes during BUSY do not affect the running computation.
- GO (offset 1): a write with `wd[0]=1` while IDLE starts a run. Writes with `wd[0]=0` are ignored. Writes while BUSY are ignored.
- Reading offset 1 returns `{31'b0, busy}`.
- STATUS (offset 2): read returns `{30'b0, err, done}`.
- RESULT (offset 3): read-only. Updated only at completion; never shows intermediate products.
- Writes to offsets 2 and 3 are ignored, except as defined under Configuration.

FSM states are IDLE and BUSY. Internal state: `cnt` (N_W bits) and `prod` (32 bits).
- IDLE, on an accepted GO with N ≤ MAX_N: `cnt<=N`, `prod<=1`, `done<=0`, `err<=0`, go to BUSY.
- IDLE, on an accepted GO with N > MAX_N: stay in IDLE; `err<=1`, `done<=1`, `result<=0`.
- BUSY, when `cnt>1`: `prod<=prod*cnt`, `cnt<=cnt-1`. The product is 32×N_W, truncated to 32 bits; no overflow is possible for N ≤ MAX_N.
- BUSY, when `cnt≤1`: `result<=prod`, `done<=1`, go to IDLE.
- `done` and `err` hold until the next accepted GO, or until the IRQ clear described under Configuration.

## Timing
- Reset values: state IDLE, N=0, `cnt`=0, `prod`=1, RESULT=0, `done`=0, `err`=0, `busy`=0, `irq`=0, `rd` reflects these.
- Reset asserted mid-run aborts immediately. After reset, RESULT reads 0.
- Label the edge that samples the GO write as E0. `busy` reads 1 after E0.
- `done` rises, and `busy` falls, at edge E0+max(N,1). Examples: N=5 at E5; N=0 or N=1 at E1.
- Error path: `done` and `err` are both 1 immediately after E0, and `busy` never asserts.
- `rd` is combinational: a read issued in the same cycle as the completing edge shows the pre-edge values.
- GO and an N write cannot coincide, because they use different offsets. A GO written in the same cycle that BUSY completes is ignored, since the state is still BUSY at that edge.

## Configuration
- `FACT_ACCEL_IRQ_EN` defined:
  - Adds output `irq`, a registered copy of `done`: `irq` rises one edge after `done` does.
  - Any write to offset 2 clears `done`, `err` and `irq` at that edge.
  - If the clear coincides with completion, completion wins.
- Not defined:
  - No `irq` port.
  - Writes to offset 2 are ignored.
  - `done` is cleared only by GO.

## Test plan
- Write N=5, then GO=1 → `busy`=1 after E0; STATUS=0x1 at E0+5; RESULT=120.
- N=0 → RESULT=1 and `done` at E0+1. N=1 → same result and timing.
- N=12 → RESULT=0x1C8CFC00 (479001600) at E0+12; `err`=0.
- N=13 → STATUS=0x3 right after E0, RESULT=0, `busy` never 1. A following N=3 GO → `err` clears; RESULT=6 at E0+3.
- N=6 GO, then N=2 and another GO mid-run → both ignored; RESULT=720 and N reads 2. Separately, a reset pulse at E0+2 → all registers return to their reset values and a fresh N=4 run yields 24.
- With `FACT_ACCEL_IRQ_EN`: N=3 → `irq`=1 at E0+4. A write to offset 2 → `irq`, `done` and `err` are 0 at the next edge.
